// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the FP multiplier result path.
package fp_mul_pkg;

  typedef logic [31:0] fp32_t;
  typedef logic [2:0]  rmode_t;

  localparam rmode_t RNE = 3'd0;
  localparam rmode_t RTZ = 3'd1;
  localparam rmode_t RDN = 3'd2;
  localparam rmode_t RUP = 3'd3;
  localparam rmode_t RMM = 3'd4;

  typedef struct packed {
    fp32_t  z;
    logic   ovrf;
    logic   udrf;
    rmode_t rm;
  } res_entry_t;

  localparam fp32_t FP_POS_INF = 32'h7F80_0000;
  localparam fp32_t FP_ZERO    = 32'h0000_0000;

endpackage

// File: rtl/fp_res_fifo.sv
// Small synchronous FIFO of result entries; head is read straight from storage
// and forced to zero while empty.
module fp_res_fifo
  import fp_mul_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  res_entry_t             i_din,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output res_entry_t             o_head,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  res_entry_t  r_mem [DEPTH];
  logic        w_pop;

  assign w_pop = i_pop & ~o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wptr[AW-1:0]] <= i_din;
  end

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_count = r_wptr - r_rptr;
  assign o_head  = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/fp_mul_result_collector.sv
// Tags multiplier issues, captures results after MUL_LAT cycles into a credited
// FIFO and keeps sticky exception flags. FP_RES_STATS_EN adds exception counters.
module fp_mul_result_collector
  import fp_mul_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        iss_valid,
  output logic        iss_ready,
  input  logic [2:0]  iss_r_mode,
  input  logic [31:0] fp_Z,
  input  logic        ovrf,
  input  logic        udrf,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_z,
  output logic        out_ovrf,
  output logic        out_udrf,
  output logic [2:0]  out_r_mode,
  output logic        sticky_ovrf,
  output logic        sticky_udrf,
  input  logic        flag_clr,
  input  logic        flush
`ifdef FP_RES_STATS_EN
  ,
  output logic [15:0] ovrf_cnt,
  output logic [15:0] udrf_cnt
`endif
);

  localparam int RW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_PARTIAL = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  logic             r_dl_vld [MUL_LAT];
  rmode_t           r_dl_rm  [MUL_LAT];
  logic [RW-1:0]    r_reserved;
  logic             r_sticky_ovrf;
  logic             r_sticky_udrf;
  logic [1:0]       r_state;

  logic             w_acc;
  logic             w_pop;
  logic             w_cap;
  res_entry_t       w_cap_entry;
  res_entry_t       w_head;
  logic             w_empty;
  logic             w_full;
  logic [CW-1:0]    w_count;
  logic [CW-1:0]    w_cnt_nxt;

  assign iss_ready   = (r_reserved < RW'(DEPTH));
  assign w_acc       = iss_valid & iss_ready;
  assign w_pop       = out_valid & out_ready;
  assign w_cap       = r_dl_vld[MUL_LAT-1] & ~flush;
  assign w_cap_entry = '{z: fp_Z, ovrf: ovrf, udrf: udrf, rm: r_dl_rm[MUL_LAT-1]};

  // Flush clears every stage, so an issue accepted in the flush cycle never gets tagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MUL_LAT; i++) begin
        r_dl_vld[i] <= 1'b0;
        r_dl_rm[i]  <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < MUL_LAT; i++) begin
        r_dl_vld[i] <= 1'b0;
        r_dl_rm[i]  <= '0;
      end
    end else begin
      for (int i = MUL_LAT - 1; i > 0; i--) begin
        r_dl_vld[i] <= r_dl_vld[i-1];
        r_dl_rm[i]  <= r_dl_rm[i-1];
      end
      r_dl_vld[0] <= w_acc;
      r_dl_rm[0]  <= iss_r_mode;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reserved <= '0;
    end else if (flush) begin
      r_reserved <= '0;
    end else if (w_acc && !w_pop) begin
      r_reserved <= r_reserved + 1'b1;
    end else if (!w_acc && w_pop) begin
      r_reserved <= r_reserved - 1'b1;
    end
  end

  fp_res_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_cap),
    .i_din   (w_cap_entry),
    .i_pop   (w_pop),
    .i_flush (flush),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (w_count)
  );

  assign out_valid  = ~w_empty;
  assign out_z      = w_head.z;
  assign out_ovrf   = w_head.ovrf;
  assign out_udrf   = w_head.udrf;
  assign out_r_mode = w_head.rm;

  // A set arriving together with a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky_ovrf <= 1'b0;
      r_sticky_udrf <= 1'b0;
    end else begin
      if (w_cap && ovrf)  r_sticky_ovrf <= 1'b1;
      else if (flag_clr)  r_sticky_ovrf <= 1'b0;
      if (w_cap && udrf)  r_sticky_udrf <= 1'b1;
      else if (flag_clr)  r_sticky_udrf <= 1'b0;
    end
  end

  assign sticky_ovrf = r_sticky_ovrf;
  assign sticky_udrf = r_sticky_udrf;

`ifdef FP_RES_STATS_EN
  logic [15:0] r_ovrf_cnt;
  logic [15:0] r_udrf_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovrf_cnt <= '0;
      r_udrf_cnt <= '0;
    end else if (flag_clr) begin
      r_ovrf_cnt <= '0;
      r_udrf_cnt <= '0;
    end else begin
      if (w_cap && ovrf && (r_ovrf_cnt != 16'hFFFF)) r_ovrf_cnt <= r_ovrf_cnt + 16'd1;
      if (w_cap && udrf && (r_udrf_cnt != 16'hFFFF)) r_udrf_cnt <= r_udrf_cnt + 16'd1;
    end
  end

  assign ovrf_cnt = r_ovrf_cnt;
  assign udrf_cnt = r_udrf_cnt;
`endif

  assign w_cnt_nxt = w_count + CW'(w_cap) - CW'(w_pop & ~w_empty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else if (flush) begin
      r_state <= ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY:   if (w_cap) r_state <= ST_PARTIAL;
        ST_PARTIAL: begin
          if (w_cnt_nxt == CW'(DEPTH))  r_state <= ST_FULL;
          else if (w_cnt_nxt == '0)     r_state <= ST_EMPTY;
        end
        ST_FULL:    if (w_pop && !w_cap) r_state <= ST_PARTIAL;
        default:    r_state <= ST_EMPTY;
      endcase
    end
  end

  // Occupancy state must always agree with the FIFO's own pointer flags.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert ((r_state == ST_EMPTY) == w_empty);
      assert ((r_state == ST_FULL) == w_full);
    end
  end

endmodule

// File: tb/tb_fp_mul_result_collector.sv
// Bench for fp_mul_result_collector: directed table, hand sequences and random
// traffic checked against a queue-based model of issue/capture/credit behaviour.
module tb_fp_mul_result_collector;
  import fp_mul_pkg::*;

  localparam int ML    = 2;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iss_valid;
  logic        iss_ready;
  logic [2:0]  iss_r_mode;
  logic [31:0] fp_Z;
  logic        ovrf;
  logic        udrf;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_z;
  logic        out_ovrf;
  logic        out_udrf;
  logic [2:0]  out_r_mode;
  logic        sticky_ovrf;
  logic        sticky_udrf;
  logic        flag_clr;
  logic        flush;
`ifdef FP_RES_STATS_EN
  logic [15:0] ovrf_cnt;
  logic [15:0] udrf_cnt;
`endif

  always #5 clk = ~clk;

  fp_mul_result_collector #(
    .MUL_LAT (ML),
    .DEPTH   (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .iss_valid   (iss_valid),
    .iss_ready   (iss_ready),
    .iss_r_mode  (iss_r_mode),
    .fp_Z        (fp_Z),
    .ovrf        (ovrf),
    .udrf        (udrf),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_z       (out_z),
    .out_ovrf    (out_ovrf),
    .out_udrf    (out_udrf),
    .out_r_mode  (out_r_mode),
    .sticky_ovrf (sticky_ovrf),
    .sticky_udrf (sticky_udrf),
    .flag_clr    (flag_clr),
    .flush       (flush)
`ifdef FP_RES_STATS_EN
    ,
    .ovrf_cnt    (ovrf_cnt),
    .udrf_cnt    (udrf_cnt)
`endif
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Operand result the bench's multiplier will return for this cycle's issue.
  fp32_t op_z;
  logic  op_o;
  logic  op_u;

  fp32_t hz [8];
  logic  ho [8];
  logic  hu [8];

  typedef struct {
    int         due;
    res_entry_t e;
  } infl_t;

  infl_t      inf  [$];
  res_entry_t outq [$];
  logic       m_so;
  logic       m_su;
  int         m_ocnt;
  int         m_ucnt;

  typedef struct {
    logic   iv;
    rmode_t rm;
    fp32_t  z;
    logic   o, u, ordy, clr;
    logic   e_rdy, e_ov;
    fp32_t  e_z;
    logic   e_o, e_u;
    rmode_t e_rm;
    logic   e_so, e_su;
  } vec_t;

  vec_t tbl [11];

  task automatic model_reset();
    inf.delete();
    outq.delete();
    m_so   = 1'b0;
    m_su   = 1'b0;
    m_ocnt = 0;
    m_ucnt = 0;
  endtask

  task automatic check_val(input string name, input logic [40:0] act, input logic [40:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic check_model(input string name);
    res_entry_t  h;
    logic        rdy;
    logic [40:0] exp;
    logic [40:0] act;
    rdy = (outq.size() + inf.size()) < DEPTH;
    h   = (outq.size() > 0) ? outq[0] : '0;
    exp = {rdy, outq.size() > 0, h, m_so, m_su};
    act = {iss_ready, out_valid, out_z, out_ovrf, out_udrf, out_r_mode, sticky_ovrf, sticky_udrf};
    check_val(name, act, exp);
`ifdef FP_RES_STATS_EN
    check_val({name, "_cnt"}, {9'd0, ovrf_cnt, udrf_cnt}, {9'd0, m_ocnt[15:0], m_ucnt[15:0]});
`endif
  endtask

  // Advance one clock: present the delayed multiplier result, update the model
  // with the inputs in force, then compare after the edge.
  task automatic step(input string name);
    logic       rdy, acc, pop, cap;
    res_entry_t ce;
    infl_t      t;
    int         k;
    k    = (cyc + 8 - ML) % 8;
    fp_Z = hz[k];
    ovrf = ho[k];
    udrf = hu[k];
    rdy  = (outq.size() + inf.size()) < DEPTH;
    acc  = iss_valid && rdy;
    pop  = (outq.size() > 0) && out_ready;
    cap  = 1'b0;
    ce   = '0;
    if (flush) begin
      outq.delete();
      inf.delete();
    end else begin
      if (pop) void'(outq.pop_front());
      if (inf.size() > 0 && inf[0].due == cyc) begin
        t   = inf.pop_front();
        ce  = t.e;
        cap = 1'b1;
        outq.push_back(ce);
      end
      if (acc) begin
        t.due    = cyc + ML;
        t.e.z    = op_z;
        t.e.ovrf = op_o;
        t.e.udrf = op_u;
        t.e.rm   = iss_r_mode;
        inf.push_back(t);
      end
    end
    if (cap && ce.ovrf) m_so = 1'b1;
    else if (flag_clr)  m_so = 1'b0;
    if (cap && ce.udrf) m_su = 1'b1;
    else if (flag_clr)  m_su = 1'b0;
    if (flag_clr) begin
      m_ocnt = 0;
      m_ucnt = 0;
    end else begin
      if (cap && ce.ovrf && m_ocnt < 65535) m_ocnt++;
      if (cap && ce.udrf && m_ucnt < 65535) m_ucnt++;
    end
    hz[cyc % 8] = op_z;
    ho[cyc % 8] = op_o;
    hu[cyc % 8] = op_u;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_model(name);
  endtask

  task automatic set_in(input logic iv, input rmode_t rm, input fp32_t z, input logic o,
                        input logic u, input logic ordy, input logic clr, input logic fl);
    iss_valid  = iv;
    iss_r_mode = rm;
    op_z       = z;
    op_o       = o;
    op_u       = u;
    out_ready  = ordy;
    flag_clr   = clr;
    flush      = fl;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      hz[i] = '0;
      ho[i] = 1'b0;
      hu[i] = 1'b0;
    end
    model_reset();
    rst_n = 1'b0;
    set_in(0, RNE, '0, 0, 0, 0, 0, 0);
    fp_Z = '0;
    ovrf = 1'b0;
    udrf = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_state",
              {iss_ready, out_valid, out_z, out_ovrf, out_udrf, out_r_mode, sticky_ovrf, sticky_udrf},
              {1'b1, 40'd0});
    rst_n = 1'b1;

    //            iv  rm   z             o  u  rdy clr | e_rdy ov  e_z           eo eu erm so su
    tbl[0]  = '{1, RNE, 32'h4000_0000, 0, 0, 1, 0,  1, 0, 32'h0,         0, 0, RNE, 0, 0};
    tbl[1]  = '{0, RNE, 32'hDEAD_BEEF, 1, 1, 1, 0,  1, 0, 32'h0,         0, 0, RNE, 0, 0};
    tbl[2]  = '{0, RNE, 32'h1234_5678, 0, 0, 1, 0,  1, 1, 32'h4000_0000, 0, 0, RNE, 0, 0};
    tbl[3]  = '{1, RUP, FP_POS_INF,    1, 0, 1, 0,  1, 0, 32'h0,         0, 0, RNE, 0, 0};
    tbl[4]  = '{1, RTZ, FP_ZERO,       0, 1, 0, 0,  1, 0, 32'h0,         0, 0, RNE, 0, 0};
    tbl[5]  = '{0, RNE, 32'hCAFE_F00D, 1, 1, 0, 0,  1, 1, FP_POS_INF,    1, 0, RUP, 1, 0};
    tbl[6]  = '{0, RNE, 32'h0BAD_BEEF, 0, 0, 1, 0,  1, 1, FP_ZERO,       0, 1, RTZ, 1, 1};
    tbl[7]  = '{1, RNE, FP_POS_INF,    1, 0, 1, 0,  1, 0, 32'h0,         0, 0, RNE, 1, 1};
    tbl[8]  = '{0, RNE, 32'h1111_1111, 0, 0, 1, 1,  1, 0, 32'h0,         0, 0, RNE, 0, 0};
    tbl[9]  = '{0, RNE, 32'h2222_2222, 0, 0, 1, 1,  1, 1, FP_POS_INF,    1, 0, RNE, 1, 0};
    tbl[10] = '{0, RNE, 32'h3333_3333, 0, 0, 1, 0,  1, 0, 32'h0,         0, 0, RNE, 1, 0};

    for (int i = 0; i < 11; i++) begin
      set_in(tbl[i].iv, tbl[i].rm, tbl[i].z, tbl[i].o, tbl[i].u, tbl[i].ordy, tbl[i].clr, 0);
      step("tbl_model");
      check_val($sformatf("tbl_row%0d", i),
                {iss_ready, out_valid, out_z, out_ovrf, out_udrf, out_r_mode, sticky_ovrf, sticky_udrf},
                {tbl[i].e_rdy, tbl[i].e_ov, tbl[i].e_z, tbl[i].e_o, tbl[i].e_u, tbl[i].e_rm,
                 tbl[i].e_so, tbl[i].e_su});
    end

    // Backpressure: five back-to-back issues with the consumer stalled.
    for (int i = 0; i < 5; i++) begin
      set_in(1, rmode_t'(i % 5), 32'h3F80_0000 + i, 0, 0, 0, 0, 0);
      step("bp_issue");
      if (i == 3) check_val("bp_ready_low", {40'd0, iss_ready}, 41'd0);
    end
    set_in(0, RNE, 32'h5555_5555, 1, 1, 0, 0, 0);
    step("bp_idle");
    step("bp_idle");
    check_val("bp_head0", {8'd0, out_valid, out_z}, {8'd0, 1'b1, 32'h3F80_0000});
    out_ready = 1'b1;
    step("bp_pop");
    check_val("bp_credit_back", {40'd0, iss_ready}, 41'd1);
    for (int j = 1; j < 4; j++) begin
      check_val($sformatf("bp_order%0d", j), {9'd0, out_z}, {9'd0, 32'h3F80_0000 + j});
      step("bp_drain");
    end
    check_val("bp_drained", {40'd0, out_valid}, 41'd0);

    // Flush with two queued entries and one result still in flight.
    set_in(1, RDN, FP_ZERO, 0, 1, 0, 0, 0);
    step("fl_issue");
    set_in(1, RMM, 32'h4040_0000, 0, 0, 0, 0, 0);
    step("fl_issue");
    set_in(0, RNE, 32'h0, 0, 0, 0, 0, 0);
    step("fl_wait");
    step("fl_wait");
    set_in(1, RNE, 32'h7777_7777, 1, 1, 0, 0, 0);
    step("fl_inflight");
    set_in(1, RUP, 32'h8888_8888, 1, 1, 1, 0, 1);
    step("fl_pulse");
    check_val("fl_after",
              {38'd0, out_valid, iss_ready, sticky_ovrf},
              {38'd0, 1'b0, 1'b1, 1'b1});
    check_val("fl_sticky_u", {40'd0, sticky_udrf}, 41'd1);
    set_in(0, RNE, 32'h0, 0, 0, 1, 0, 0);
    for (int j = 0; j < 3; j++) begin
      step("fl_quiet");
      check_val("fl_no_ghost", {40'd0, out_valid}, 41'd0);
    end

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 3) != 0, rmode_t'($urandom_range(0, 4)), fp32_t'($urandom),
             $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 40) == 0);
      step("rand");
    end

    // Asynchronous reset while the FIFO is full.
    for (int i = 0; i < 6; i++) begin
      set_in(1, RUP, 32'h4100_0000 + i, 1, 0, 0, 0, 0);
      step("rst_fill");
    end
    set_in(0, RNE, 32'h0, 0, 0, 0, 0, 0);
    step("rst_fill");
    step("rst_fill");
    step("rst_fill");
    check_val("rst_pre_full", {39'd0, out_valid, iss_ready}, {39'd0, 1'b1, 1'b0});
    rst_n = 1'b0;
    #1;
    check_val("rst_async",
              {iss_ready, out_valid, out_z, out_ovrf, out_udrf, out_r_mode, sticky_ovrf, sticky_udrf},
              {1'b1, 40'd0});
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step("rst_release");
    check_val("rst_ready", {40'd0, iss_ready}, 41'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
